// File: rtl/alu_defs_pkg.sv
// alu_defs_pkg: ALU opcode constants and serial add/sub FSM state encoding
package alu_defs_pkg;
   localparam logic [2:0] ADD     = 3'd0;
   localparam logic [2:0] SUB     = 3'd1;
   localparam logic [2:0] XOR_SEL = 3'd2;
   localparam logic [2:0] SLT     = 3'd3;
   localparam logic [2:0] AND_SEL = 3'd4;
   localparam logic [2:0] NAND    = 3'd5;
   localparam logic [2:0] NOR     = 3'd6;
   localparam logic [2:0] OR_SEL  = 3'd7;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/addsub_serial_if.sv
// addsub_serial_if: operand/command input and result/flag output handshakes
interface addsub_serial_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       command;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carryout;
   logic             overflow;
   logic             zero;
   modport master (output in_valid, a, b, command, out_ready,
                   input  in_ready, out_valid, result, carryout, overflow, zero);
   modport slave  (input  in_valid, a, b, command, out_ready,
                   output in_ready, out_valid, result, carryout, overflow, zero);
endinterface

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit adder with optional B inversion
module addsub_chunk #(parameter int CHUNK = 8) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             inv_b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b ^ {CHUNK{inv_b}}} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: multicycle add/sub/slt, CHUNK bits per clock with registered carry
module addsub_serial
   import alu_defs_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic clk,
   input  logic reset_n,
   addsub_serial_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, raw;
   logic [2:0]       cmd_q, cmd_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
   logic             sub, sup, c_out, r_msb, ovf;
   logic [CHUNK-1:0] a_c, b_c, s_c;

   assign sub = (cmd_q == SUB) || (cmd_q == SLT);
   assign sup = sub || (cmd_q == ADD);
   assign a_c = a_q[idx_q*CHUNK +: CHUNK];
   assign b_c = b_q[idx_q*CHUNK +: CHUNK];

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a(a_c), .b(b_c), .inv_b(sub), .cin(carry_q), .sum(s_c), .cout(c_out)
   );

   // merge the current chunk sum into the result and derive signed overflow from the raw MSB
   always_comb begin
      raw = res_q;
      raw[idx_q*CHUNK +: CHUNK] = s_c;
      r_msb = raw[WIDTH-1];
      ovf = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub)) && (r_msb != a_q[WIDTH-1]);
   end

   // next-state, chunk sequencing and flag finalisation
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cmd_d   = cmd_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      res_d   = res_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: if (bus.in_valid) begin
            a_d     = bus.a;
            b_d     = bus.b;
            cmd_d   = bus.command;
            carry_d = (bus.command == SUB) || (bus.command == SLT);
            idx_d   = '0;
            res_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            res_d   = raw;
            carry_d = c_out;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
               state_d = DONE;
               cout_d  = sup & c_out;
               ovf_d   = sup & ovf;
               res_d   = !sup ? '0 : (cmd_q == SLT) ? {{(WIDTH-1){1'b0}}, r_msb ^ ovf} : raw;
               zero_d  = ~|res_d;
            end
         end
         DONE: state_d = bus.out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cmd_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cmd_q   <= cmd_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) & reset_n;
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = res_q;
   assign bus.carryout  = cout_q;
   assign bus.overflow  = ovf_q;
   assign bus.zero      = zero_q;
endmodule
